mod_reduce_unit: RTL

MOD_REDUCE_UNIT -- requirements
Module: mod_reduce_unit

---
 rtl/mod_reduce_pkg.sv | 11 +
 rtl/mod_sub_step.sv | 23 ++
 rtl/mod_reduce_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mod_reduce_pkg.sv
// rtl/mod_reduce_pkg.sv - shared FSM state type and default widths for mod_reduce_unit
package mod_reduce_pkg;
   localparam int DEF_IN_W  = 12;
   localparam int DEF_DIV_W = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/mod_sub_step.sv
// rtl/mod_sub_step.sv - one restoring step: shift in a dividend bit, trial subtract, select
module mod_sub_step
   import mod_reduce_pkg::*;
#(
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic [DIV_W-1:0] i_rem,
   input  logic             i_bit,
   input  logic [DIV_W-1:0] i_div,
   output logic [DIV_W-1:0] o_rem,
   output logic             o_q_bit
);
   logic [DIV_W:0] w_shift;
   logic [DIV_W:0] w_sub;
   logic           w_ge;

   // The incoming remainder is always below the divisor, so the extra shift bit suffices.
   assign w_shift = {i_rem, i_bit};
   assign w_ge    = (w_shift >= {1'b0, i_div});
   assign w_sub   = w_shift - {1'b0, i_div};
   assign o_rem   = DIV_W'(w_ge ? w_sub : w_shift);
   assign o_q_bit = w_ge;
endmodule

// File: rtl/mod_reduce_unit.sv
// rtl/mod_reduce_unit.sv - sequential restoring modulo reduction, one dividend bit per cycle
// Optional quotient output enabled by MOD_REDUCE_QUOTIENT_EN.
module mod_reduce_unit
   import mod_reduce_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int DIV_W = DEF_DIV_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [IN_W-1:0]   func_in,
   input  logic [DIV_W-1:0]  div,
   output logic              busy,
   output logic              done,
   output logic [DIV_W-1:0]  func_out,
   output logic              err
`ifdef MOD_REDUCE_QUOTIENT_EN
   ,
   output logic [IN_W-1:0]   quot
`endif
);
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

   state_t             r_state;
   logic [IN_W-1:0]    r_dvd;
   logic [DIV_W-1:0]   r_div;
   logic [DIV_W-1:0]   r_rem;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [DIV_W-1:0]   r_func_out;
   logic [DIV_W-1:0]   w_rem_next;
   logic               w_q_bit;
`ifdef MOD_REDUCE_QUOTIENT_EN
   logic [IN_W-1:0]    r_quot;
`endif

   mod_sub_step #(.DIV_W(DIV_W)) u_step (
      .i_rem   (r_rem),
      .i_bit   (r_dvd[IN_W-1]),
      .i_div   (r_div),
      .o_rem   (w_rem_next),
      .o_q_bit (w_q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_dvd      <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_cnt      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_func_out <= '0;
`ifdef MOD_REDUCE_QUOTIENT_EN
         r_quot     <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_dvd  <= func_in;
                  r_div  <= div;
                  r_rem  <= '0;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  if (div == '0) begin
                     r_state    <= ST_DONE;
                     r_err      <= 1'b1;
                     r_func_out <= '0;
`ifdef MOD_REDUCE_QUOTIENT_EN
                     r_quot     <= '0;
`endif
                  end else begin
                     r_state <= ST_CALC;
                     r_err   <= 1'b0;
                  end
               end
            end
            ST_CALC: begin
               // Dividend bits leave at the MSB while quotient bits enter at the LSB.
               r_rem <= w_rem_next;
               r_dvd <= {r_dvd[IN_W-2:0], w_q_bit};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(IN_W - 1)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               if (!r_err) begin
                  r_func_out <= r_rem;
`ifdef MOD_REDUCE_QUOTIENT_EN
                  r_quot     <= r_dvd;
`endif
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign func_out = r_func_out;
   assign err      = r_err;
`ifdef MOD_REDUCE_QUOTIENT_EN
   assign quot     = r_quot;
`endif
endmodule
